mem_stage_lsu: RTL and testbench

- Load/store unit in the MEM stage; consumes the EX-stage address (alu_result) and store data (rs2_data), and drives the data-memory request/acknowledge bus.
- Generates byte strobes, aligns store data, and sign/zero-extends load data.
- Stalls the pipeline while a bus transaction is outstanding.
- Reports misalignment and bus-timeout faults.

---
 rtl/mem_stage_lsu.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte strobes, store lane replication, load extension,
// bus handshake with timeout. Define MISALIGN_TRAP_EN to fault misaligned accesses.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] load_data,
    output logic        misalign_fault,
    output logic        bus_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [31:0]     addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [3:0]      wstrb_reg, wstrb_next;
    logic [2:0]      f3_reg, f3_next;
    logic            we_reg, we_next;
    logic [31:0]     load_data_reg, load_data_next;
    logic            mis_flag_reg, mis_flag_next;
    logic            bus_flag_reg, bus_flag_next;

    logic            start, in_wait, misaligned;
    logic            is_byte, is_half, is_word;
    logic [3:0]      wstrb_calc;
    logic [31:0]     wdata_calc, load_ext;
    logic [7:0]      rd_lane [4];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = funct3[1];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Gating with rst keeps stall low during reset even if the pipeline presents a valid access.
    assign start   = in_valid & (mem_read | mem_write) & ~flush & (state_reg == S_IDLE) & ~rst;
    assign in_wait = (state_reg == S_WAIT);

    assign stall          = start | in_wait;
    assign result_valid   = (state_reg == S_RESP);
    assign load_data      = load_data_reg;
    assign misalign_fault = result_valid & mis_flag_reg;
    assign bus_fault      = result_valid & bus_flag_reg;
    assign dmem_req       = in_wait;
    assign dmem_we        = in_wait & we_reg;
    assign dmem_addr      = {addr_reg[31:2], 2'b00};
    assign dmem_wdata     = wdata_reg;
    assign dmem_wstrb     = in_wait ? wstrb_reg : 4'b0000;

    // Halfword and word strobes ignore the low address bits, which gives natural alignment.
    always_comb begin
        wstrb_calc = 4'b1111;
        wdata_calc = store_data;
        if (is_byte) begin
            wstrb_calc = 4'b0001 << addr[1:0];
            wdata_calc = {4{store_data[7:0]}};
        end else if (is_half) begin
            wstrb_calc = 4'b0011 << {addr[1], 1'b0};
            wdata_calc = {2{store_data[15:0]}};
        end
        if (!mem_write) begin
            wstrb_calc = 4'b0000;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rd_lane[addr_reg[1:0]];
    assign half_sel = addr_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (f3_reg[1:0])
            2'b00:   load_ext = {{24{~f3_reg[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~f3_reg[2] & half_sel[15]}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        f3_next        = f3_reg;
        we_next        = we_reg;
        load_data_next = load_data_reg;
        mis_flag_next  = mis_flag_reg;
        bus_flag_next  = bus_flag_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next      = addr;
                    wdata_next     = wdata_calc;
                    wstrb_next     = wstrb_calc;
                    f3_next        = funct3;
                    we_next        = mem_write;
                    cnt_next       = '0;
                    load_data_next = '0;
                    bus_flag_next  = 1'b0;
                    mis_flag_next  = misaligned;
                    state_next     = misaligned ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Ack takes priority over the timeout in the limit cycle.
                if (dmem_ack) begin
                    load_data_next = we_reg ? 32'h0 : load_ext;
                    state_next     = S_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST)) begin
                    bus_flag_next  = 1'b1;
                    state_next     = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_RESP: begin
                load_data_next = '0;
                mis_flag_next  = 1'b0;
                bus_flag_next  = 1'b0;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            f3_reg        <= '0;
            we_reg        <= 1'b0;
            load_data_reg <= '0;
            mis_flag_reg  <= 1'b0;
            bus_flag_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            f3_reg        <= f3_next;
            we_reg        <= we_next;
            load_data_reg <= load_data_next;
            mis_flag_reg  <= mis_flag_next;
            bus_flag_reg  <= bus_flag_next;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu with a behavioural bus responder and hand-computed vectors.
module tb_mem_stage_lsu;
    logic        clk, rst, in_valid, flush, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, result_valid, misalign_fault, bus_fault;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int n_vec = 0;
    int n_err = 0;

    int          obs_stall, obs_req, obs_rv, obs_mis, obs_bus, obs_lat;
    logic        obs_done, obs_we, obs_stall_at_rv;
    logic [31:0] obs_addr, obs_wdata, obs_load;
    logic [3:0]  obs_wstrb;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .store_data(store_data), .stall(stall),
        .result_valid(result_valid), .load_data(load_data),
        .misalign_fault(misalign_fault), .bus_fault(bus_fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one access; ack_after = WAIT cycle index carrying the ack (0 = never ack).
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input int ack_after, input logic [31:0] rdata);
        int  waits;
        bit  seen;
        waits = 0; seen = 0;
        obs_stall = 0; obs_req = 0; obs_rv = 0; obs_mis = 0; obs_bus = 0; obs_lat = -1;
        obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_we = 0; obs_load = '0; obs_stall_at_rv = 1;
        @(posedge clk); #1;
        in_valid = 1; mem_write = we; mem_read = ~we; funct3 = f3; addr = a; store_data = sd;
        dmem_rdata = rdata;
        for (int c = 0; c < 64 && !seen; c++) begin
            if (dmem_req) begin
                waits++;
                dmem_ack = (ack_after != 0) && (waits == ack_after);
            end else begin
                dmem_ack = 0;
            end
            #1;
            if (stall) obs_stall++;
            if (dmem_req) begin
                obs_req++; obs_addr = dmem_addr; obs_wdata = dmem_wdata;
                obs_wstrb = dmem_wstrb; obs_we = dmem_we;
            end
            if (misalign_fault) obs_mis++;
            if (bus_fault) obs_bus++;
            if (result_valid) begin
                obs_rv++; obs_load = load_data; obs_lat = c; obs_stall_at_rv = stall; seen = 1;
                in_valid = 0; mem_read = 0; mem_write = 0;
            end
            @(posedge clk); #1;
        end
        dmem_ack = 0;
        in_valid = 0; mem_read = 0; mem_write = 0;
        #1;
        if (result_valid) obs_rv++;
        if (stall) obs_stall++;
        obs_done = seen;
        $display("access we=%0b f3=%03b addr=%08h sd=%08h -> req_cyc=%0d stall_cyc=%0d lat=%0d addr=%08h wstrb=%04b wdata=%08h load=%08h mis=%0d bus=%0d",
                 we, f3, a, sd, obs_req, obs_stall, obs_lat, obs_addr, obs_wstrb, obs_wdata, obs_load, obs_mis, obs_bus);
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; flush = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        addr = 0; store_data = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1; mem_read = 1;
        #1;
        n_vec++; if ({stall, result_valid, dmem_req, dmem_we, misalign_fault, bus_fault} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl got %06b want 000000", {stall, result_valid, dmem_req, dmem_we, misalign_fault, bus_fault}); end
        n_vec++; if ({load_data, dmem_addr, dmem_wdata, dmem_wstrb} !== 100'h0) begin n_err++; $display("FAIL reset_data got %h %h %h %h want 0", load_data, dmem_addr, dmem_wdata, dmem_wstrb); end
        in_valid = 0; mem_read = 0;
        @(posedge clk); #1; rst = 0;
        $display("reset done");
    endtask

    task automatic test_store_word();
        run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        n_vec++; if (obs_done !== 1'b1) begin n_err++; $display("FAIL sw_done got %0b want 1", obs_done); end
        n_vec++; if (obs_addr !== 32'h100 || obs_wstrb !== 4'b1111 || obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin n_err++; $display("FAIL sw_bus got %08h %04b %08h %0b want 00000100 1111 deadbeef 1", obs_addr, obs_wstrb, obs_wdata, obs_we); end
        n_vec++; if (obs_stall !== 3 || obs_req !== 2) begin n_err++; $display("FAIL sw_stall got stall=%0d req=%0d want 3 2", obs_stall, obs_req); end
        n_vec++; if (obs_lat !== 3 || obs_rv !== 1 || obs_load !== 32'h0 || obs_stall_at_rv !== 1'b0) begin n_err++; $display("FAIL sw_resp got lat=%0d rv=%0d load=%08h st=%0b want 3 1 0 0", obs_lat, obs_rv, obs_load, obs_stall_at_rv); end
    endtask

    task automatic test_load_byte();
        run_access(1'b0, 3'b000, 32'h203, 32'h0, 1, 32'h80FFFF7F);
        n_vec++; if (obs_load !== 32'hFFFFFF80 || obs_lat !== 2) begin n_err++; $display("FAIL lb got %08h lat=%0d want ffffff80 2", obs_load, obs_lat); end
        n_vec++; if (obs_wstrb !== 4'b0000 || obs_we !== 1'b0 || obs_addr !== 32'h200) begin n_err++; $display("FAIL lb_bus got %04b %0b %08h want 0000 0 00000200", obs_wstrb, obs_we, obs_addr); end
        run_access(1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80FFFF7F);
        n_vec++; if (obs_load !== 32'h00000080) begin n_err++; $display("FAIL lbu got %08h want 00000080", obs_load); end
        run_access(1'b0, 3'b000, 32'h200, 32'h0, 1, 32'h80FFFF7F);
        n_vec++; if (obs_load !== 32'h0000007F) begin n_err++; $display("FAIL lb_lane0 got %08h want 0000007f", obs_load); end
    endtask

    task automatic test_store_sub();
        run_access(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 1, 32'h0);
        n_vec++; if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h10) begin n_err++; $display("FAIL sh got %04b %08h %08h want 1100 abcdabcd 00000010", obs_wstrb, obs_wdata, obs_addr); end
        run_access(1'b1, 3'b000, 32'h101, 32'h12345678, 1, 32'h0);
        n_vec++; if (obs_wstrb !== 4'b0010 || obs_wdata !== 32'h78787878) begin n_err++; $display("FAIL sb got %04b %08h want 0010 78787878", obs_wstrb, obs_wdata); end
    endtask

    task automatic test_load_half();
        run_access(1'b0, 3'b001, 32'h206, 32'h0, 3, 32'h80017FFF);
        n_vec++; if (obs_load !== 32'hFFFF8001 || obs_req !== 3) begin n_err++; $display("FAIL lh got %08h req=%0d want ffff8001 3", obs_load, obs_req); end
        run_access(1'b0, 3'b101, 32'h206, 32'h0, 1, 32'h80017FFF);
        n_vec++; if (obs_load !== 32'h00008001) begin n_err++; $display("FAIL lhu got %08h want 00008001", obs_load); end
        run_access(1'b0, 3'b001, 32'h204, 32'h0, 1, 32'h80017FFF);
        n_vec++; if (obs_load !== 32'h00007FFF) begin n_err++; $display("FAIL lh_lo got %08h want 00007fff", obs_load); end
    endtask

    task automatic test_misalign();
        run_access(1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h11223344);
`ifdef MISALIGN_TRAP_EN
        n_vec++; if (obs_req !== 0 || obs_mis !== 1 || obs_stall !== 1) begin n_err++; $display("FAIL misalign_trap got req=%0d mis=%0d stall=%0d want 0 1 1", obs_req, obs_mis, obs_stall); end
        n_vec++; if (obs_rv !== 1 || obs_load !== 32'h0 || obs_lat !== 1) begin n_err++; $display("FAIL misalign_resp got rv=%0d load=%08h lat=%0d want 1 0 1", obs_rv, obs_load, obs_lat); end
`else
        n_vec++; if (obs_addr !== 32'h100 || obs_load !== 32'h11223344 || obs_mis !== 0) begin n_err++; $display("FAIL misalign_mask got %08h %08h mis=%0d want 00000100 11223344 0", obs_addr, obs_load, obs_mis); end
        n_vec++; if (obs_req !== 1 || obs_lat !== 2) begin n_err++; $display("FAIL misalign_lat got req=%0d lat=%0d want 1 2", obs_req, obs_lat); end
`endif
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        n_vec++; if (obs_req !== 4 || obs_stall !== 5) begin n_err++; $display("FAIL timeout_len got req=%0d stall=%0d want 4 5", obs_req, obs_stall); end
        n_vec++; if (obs_bus !== 1 || obs_rv !== 1 || obs_stall_at_rv !== 1'b0 || obs_load !== 32'h0) begin n_err++; $display("FAIL timeout_resp got bus=%0d rv=%0d st=%0b load=%08h want 1 1 0 0", obs_bus, obs_rv, obs_stall_at_rv, obs_load); end
        run_access(1'b0, 3'b010, 32'h304, 32'h0, 4, 32'hCAFEF00D);
        n_vec++; if (obs_bus !== 0 || obs_load !== 32'hCAFEF00D) begin n_err++; $display("FAIL ack_at_limit got bus=%0d load=%08h want 0 cafef00d", obs_bus, obs_load); end
    endtask

    task automatic test_reset_mid_wait();
        int rv_cnt;
        rv_cnt = 0;
        @(posedge clk); #1;
        in_valid = 1; mem_read = 1; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rstwait_req got %0b want 1", dmem_req); end
        rst = 1;
        #1;
        n_vec++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL rstwait_drop got req=%0b stall=%0b want 0 0", dmem_req, stall); end
        in_valid = 0; mem_read = 0;
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1; dmem_ack = 1; dmem_rdata = 32'h55AA55AA;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1; dmem_ack = 0;
            if (result_valid) rv_cnt++;
        end
        n_vec++; if (rv_cnt !== 0) begin n_err++; $display("FAIL late_ack got rv=%0d want 0", rv_cnt); end
        $display("reset mid-wait: late ack result pulses=%0d", rv_cnt);
    endtask

    task automatic test_flush();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        in_valid = 1; mem_read = 1; flush = 1; funct3 = 3'b010; addr = 32'h500;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (stall || dmem_req || result_valid) bad++;
            @(posedge clk); #1;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL flush got %0d active cycles want 0", bad); end
        in_valid = 0; mem_read = 0; flush = 0;
        $display("flush in idle: active cycles=%0d", bad);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_sub();
        test_load_half();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
